// File: rtl/debounce_edge_detect.sv
// rtl/debounce_edge_detect.sv - stable-count debouncer with registered level and rise/fall pulses
// Optional press counter enabled by defining DEBOUNCE_PRESS_CNT_EN.
module debounce_edge_detect #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d,
    output logic       level,
    output logic       rise,
    output logic       fall
`ifdef DEBOUNCE_PRESS_CNT_EN
    ,
    output logic [7:0] press_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } state_t;

    // The last count value before acceptance; reaching it while d still differs
    // means this edge is the STABLE_CYCLES-th consecutive differing sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
`ifdef DEBOUNCE_PRESS_CNT_EN
            press_cnt <= 8'd0;
`endif
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (d) begin
                        state <= WAIT_HIGH;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!d) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                        level <= 1'b1;
                        rise  <= 1'b1;
`ifdef DEBOUNCE_PRESS_CNT_EN
                        press_cnt <= press_cnt + 8'd1;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!d) begin
                        state <= WAIT_LOW;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (d) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_edge_detect.sv
// tb/tb_debounce_edge_detect.sv - scoreboard bench for debounce_edge_detect with STABLE_CYCLES=4
// Press-counter checks are active when DEBOUNCE_PRESS_CNT_EN is defined.
module tb_debounce_edge_detect;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d   = 1'b0;
    logic       level;
    logic       rise;
    logic       fall;
`ifdef DEBOUNCE_PRESS_CNT_EN
    logic [7:0] press_cnt;
`endif

    debounce_edge_detect #(
        .STABLE_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .d    (d),
        .level(level),
        .rise (rise),
        .fall (fall)
`ifdef DEBOUNCE_PRESS_CNT_EN
        ,
        .press_cnt(press_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lvl;
        logic       rs;
        logic       fl;
        logic [7:0] pc;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_press = 8'd0;

    // Drive one clock's inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic din, input logic el,
                        input logic er, input logic ef, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r;
        d   = din;
        if (r) exp_press = 8'd0;
        else if (er) exp_press = exp_press + 8'd1;
        e.lvl = el;
        e.rs  = er;
        e.fl  = ef;
        e.pc  = exp_press;
        e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic ok;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                ok = (level === e.lvl) && (rise === e.rs) && (fall === e.fl);
`ifdef DEBOUNCE_PRESS_CNT_EN
                ok = ok && (press_cnt === e.pc);
                if (!ok)
                    $display("FAIL %s: got level=%0b rise=%0b fall=%0b press_cnt=%0d, want level=%0b rise=%0b fall=%0b press_cnt=%0d",
                             e.tag, level, rise, fall, press_cnt, e.lvl, e.rs, e.fl, e.pc);
`else
                if (!ok)
                    $display("FAIL %s: got level=%0b rise=%0b fall=%0b, want level=%0b rise=%0b fall=%0b",
                             e.tag, level, rise, fall, e.lvl, e.rs, e.fl);
`endif
                if (!ok) n_bad++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        // Reset, then d held high: level rises on the 4th edge.
        step(1, 0, 0, 0, 0, "reset_0");
        step(1, 0, 0, 0, 0, "reset_1");
        step(0, 1, 0, 0, 0, "hold_high_e1");
        step(0, 1, 0, 0, 0, "hold_high_e2");
        step(0, 1, 0, 0, 0, "hold_high_e3");
        step(0, 1, 1, 1, 0, "hold_high_e4_rise");
        step(0, 1, 1, 0, 0, "rise_clears");

        // From level=1, d held low: fall on the 4th edge.
        step(0, 0, 1, 0, 0, "hold_low_e1");
        step(0, 0, 1, 0, 0, "hold_low_e2");
        step(0, 0, 1, 0, 0, "hold_low_e3");
        step(0, 0, 0, 0, 1, "hold_low_e4_fall");
        step(0, 0, 0, 0, 0, "fall_clears");

        // Two highs, a bounce low, then four highs: a single rise.
        step(0, 1, 0, 0, 0, "bounce_hi1");
        step(0, 1, 0, 0, 0, "bounce_hi2");
        step(0, 0, 0, 0, 0, "bounce_lo");
        step(0, 1, 0, 0, 0, "bounce_re1");
        step(0, 1, 0, 0, 0, "bounce_re2");
        step(0, 1, 0, 0, 0, "bounce_re3");
        step(0, 1, 1, 1, 0, "bounce_re4_rise");
        step(0, 1, 1, 0, 0, "bounce_hold");
        step(0, 0, 1, 0, 0, "back_low_e1");
        step(0, 0, 1, 0, 0, "back_low_e2");
        step(0, 0, 1, 0, 0, "back_low_e3");
        step(0, 0, 0, 0, 1, "back_low_e4_fall");

        // d toggling every cycle never changes level.
        for (int i = 0; i < 50; i++)
            step(0, (i % 2) == 0, 0, 0, 0, "toggle");

        // Reset mid-wait aborts the change; a full 4 edges are needed afterwards.
        step(0, 1, 0, 0, 0, "abort_e1");
        step(0, 1, 0, 0, 0, "abort_e2");
        step(0, 1, 0, 0, 0, "abort_e3");
        step(1, 1, 0, 0, 0, "abort_rst");
        step(0, 1, 0, 0, 0, "after_rst_e1");
        step(0, 1, 0, 0, 0, "after_rst_e2");
        step(0, 1, 0, 0, 0, "after_rst_e3");
        step(0, 1, 1, 1, 0, "after_rst_e4_rise");
        step(0, 1, 1, 0, 0, "after_rst_hold");

        // Constant input produces no pulses.
        for (int i = 0; i < 8; i++)
            step(0, 1, 1, 0, 0, "const_high");

`ifdef DEBOUNCE_PRESS_CNT_EN
        step(1, 0, 0, 0, 0, "press_reset");
        for (int p = 0; p < 257; p++) begin
            step(0, 1, 0, 0, 0, "press_hi1");
            step(0, 1, 0, 0, 0, "press_hi2");
            step(0, 1, 0, 0, 0, "press_hi3");
            step(0, 1, 1, 1, 0, "press_rise");
            step(0, 0, 1, 0, 0, "press_lo1");
            step(0, 0, 1, 0, 0, "press_lo2");
            step(0, 0, 1, 0, 0, "press_lo3");
            step(0, 0, 0, 0, 1, "press_fall");
        end
        step(0, 0, 0, 0, 0, "press_wrapped");
        step(1, 0, 0, 0, 0, "press_rst_clear");
`endif

        for (int k = 0; k < 20 && sb.size() > 0; k++)
            @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
